imem_loader: RTL and testbench

Boot-time sequencer for the instruction memory and fetch unit. It holds the core in PC reset, receives a framed program image over a byte-wide valid/ready stream, and assembles little-endian 32-bit words. It writes each word into instruction memory through the memory's write port (`IWR_EN`/`DATA`/address). When the checksum matches, it switches the memory to read mode and releases the program counter.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 109 ++++++++++
 tb/tb_imem_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } loader_state_t;

  localparam int CSUM_W = 8;
  localparam int LANES  = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; pulses word_valid
// for one cycle after the fourth lane has been filled.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic [7:0]           byte_in,
  output logic [8*LANES-1:0]   word,
  output logic                 lane_last,
  output logic                 word_valid
);

  logic [1:0] lane;

  assign lane_last = (lane == 2'(LANES - 1));

  // The word register doubles as the memory write-data output, so it is reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= '0;
      end else if (load) begin
        word[{lane, 3'b000} +: 8] <= byte_in;
        lane                      <= lane + 2'd1;
        word_valid                <= lane_last;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length/data/checksum frame, writes words into
// instruction memory and releases the fetch unit once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  input  logic        reload_i,
  output logic        IWR_EN_o,
  output logic        IR_EN_o,
  output logic [31:0] address_o,
  output logic [31:0] DATA_o,
  output logic        PCrst_o,
  output logic        done_o,
  output logic        err_o
);

  loader_state_t     state;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  n_len;
  logic [LEN_W-1:0]  n_rx;
  logic [LEN_W-1:0]  word_idx;
  logic [CSUM_W-1:0] csum;
  logic [31:0]       address_q;
  logic              rx_ready;
  logic              accept;
  logic              pack_clr;
  logic              pack_load;
  logic              lane_last;
  logic              word_valid;
  logic [31:0]       word;

  assign rx_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
  assign accept    = rx_valid_i && rx_ready;
  assign n_rx      = LEN_W'({rx_data_i, len_lo});
  assign pack_clr  = accept && (state == S_LEN_HI);
  assign pack_load = accept && (state == S_DATA);

  byte_packer u_packer (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (pack_clr),
    .load       (pack_load),
    .byte_in    (rx_data_i),
    .word       (word),
    .lane_last  (lane_last),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_LEN_LO;
      len_lo    <= '0;
      n_len     <= '0;
      word_idx  <= '0;
      csum      <= '0;
      address_q <= '0;
    end else begin
      case (state)
        S_LEN_LO: if (accept) begin
          len_lo <= rx_data_i;
          state  <= S_LEN_HI;
        end
        S_LEN_HI: if (accept) begin
          n_len    <= n_rx;
          word_idx <= '0;
          csum     <= '0;
          if (32'(n_rx) > DEPTH)   state <= S_ERR;
          else if (n_rx == '0)     state <= S_CSUM;
          else                     state <= S_DATA;
        end
        S_DATA: if (accept) begin
          csum <= csum + CSUM_W'(rx_data_i);
          // Latch the address as the last lane lands so it is valid throughout WRITE.
          if (lane_last) begin
            address_q <= 32'(word_idx) << 2;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + LEN_W'(1);
          state    <= (word_idx + LEN_W'(1) == n_len) ? S_CSUM : S_DATA;
        end
        S_CSUM: if (accept) begin
          state <= (rx_data_i == 8'(csum)) ? S_RUN : S_ERR;
        end
        S_RUN, S_ERR: if (reload_i) state <= S_LEN_LO;
        default: state <= S_LEN_LO;
      endcase
    end
  end

  assign rx_ready_o = rx_ready;
  assign IWR_EN_o   = word_valid;
  assign IR_EN_o    = (state == S_RUN);
  assign done_o     = (state == S_RUN);
  assign PCrst_o    = (state != S_RUN);
  assign err_o      = (state == S_ERR);
  assign address_o  = address_q;
  assign DATA_o     = word;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from a word list and the
// expected write trace / final status is derived from the frame rules.
module tb_imem_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        iwr_en, ir_en, pc_rst, done, err;
  logic [31:0] address, data;

  int tests = 0;
  int failed = 0;

  logic [31:0] img_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.DEPTH(DEPTH), .LEN_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .rx_ready_o (rx_ready),
    .reload_i   (reload),
    .IWR_EN_o   (iwr_en),
    .IR_EN_o    (ir_en),
    .address_o  (address),
    .DATA_o     (data),
    .PCrst_o    (pc_rst),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor
  always @(negedge clk) begin
    if (!rst && iwr_en) begin
      wr_addr_q.push_back(address);
      wr_data_q.push_back(data);
      chk("ready_in_write", rx_ready, 1'b0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pcrst"}, pc_rst, 1'b1);
    chk({tag, "_iwr"},   iwr_en, 1'b0);
    chk({tag, "_ir"},    ir_en,  1'b0);
    chk({tag, "_addr"},  address, 32'h0);
    chk({tag, "_data"},  data,   32'h0);
    chk({tag, "_done"},  done,   1'b0);
    chk({tag, "_err"},   err,    1'b0);
    chk({tag, "_ready"}, rx_ready, 1'b1);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    chk("reload_pcrst", pc_rst, 1'b1);
    chk("reload_done",  done,   1'b0);
    chk("reload_err",   err,    1'b0);
    chk("reload_ready", rx_ready, 1'b1);
  endtask

  // Sends length n, img_q[0..n-1] and a checksum byte (csum_ovr < 0 = correct sum).
  task automatic run_frame(input int n, input int csum_ovr, input int gap_max);
    int          sum;
    logic [7:0]  csum_tx;
    logic [31:0] w;
    bit          good;
    logic [15:0] len;
    wr_addr_q.delete();
    wr_data_q.delete();
    len = 16'(n);
    send_byte(len[7:0], gap_max);
    send_byte(len[15:8], gap_max);
    if (n > DEPTH) begin
      repeat (3) @(negedge clk);
      chk("ovs_err",    err,    1'b1);
      chk("ovs_pcrst",  pc_rst, 1'b1);
      chk("ovs_ready",  rx_ready, 1'b0);
      chk("ovs_writes", 64'(wr_addr_q.size()), 64'd0);
      return;
    end
    sum = 0;
    for (int i = 0; i < n; i++) begin
      w = img_q[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], gap_max);
        sum += int'(w[8*b +: 8]);
      end
    end
    csum_tx = (csum_ovr < 0) ? 8'(sum) : 8'(csum_ovr);
    good    = (csum_tx == 8'(sum));
    send_byte(csum_tx, gap_max);
    chk("end_done",  done,   good);
    chk("end_ir",    ir_en,  good);
    chk("end_pcrst", pc_rst, !good);
    chk("end_err",   err,    !good);
    chk("end_ready", rx_ready, 1'b0);
    chk("wr_count",  64'(wr_addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk($sformatf("wr_addr%0d", i), wr_addr_q[i], 32'(i * 4));
      chk($sformatf("wr_data%0d", i), wr_data_q[i], img_q[i]);
    end
    if (n > 0) begin
      chk("hold_addr", address, 32'((n - 1) * 4));
      chk("hold_data", data,    img_q[n - 1]);
    end
    // Bytes offered after completion must not be taken.
    @(negedge clk);
    rx_valid = 1'b1;
    @(negedge clk);
    chk("post_ready", rx_ready, 1'b0);
    chk("post_state", {done, err}, {good, !good});
    rx_valid = 1'b0;
  endtask

  task automatic random_image(input int n);
    img_q.delete();
    for (int i = 0; i < n; i++) img_q.push_back($urandom);
  endtask

  initial begin
    #1;
    check_reset_vals("rst_hold");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_rel");

    img_q.delete();
    img_q.push_back(32'h0000_0013);
    img_q.push_back(32'hDEAD_BEEF);
    run_frame(2, -1, 0);
    do_reload();

    run_frame(2, 8'h00, 0);
    do_reload();

    run_frame(DEPTH + 1, -1, 0);
    do_reload();

    run_frame(0, 8'h00, 0);
    do_reload();

    random_image(16);
    run_frame(16, -1, 3);
    do_reload();

    for (int r = 0; r < 3; r++) begin
      random_image(int'($urandom_range(24, 1)));
      run_frame(img_q.size(), (r == 1) ? int'($urandom_range(255, 0)) : -1, 2);
      do_reload();
    end

    // Reset in the middle of a frame, off the clock edge.
    random_image(4);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 6; b++) send_byte(8'($urandom), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    random_image(3);
    run_frame(3, -1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
